// File: rtl/adc_sample_fifo.sv
// ADC sample capture on rising edges of a same-domain 10MHz level, buffered in a FWFT FIFO.
// Define ADC_OTR_FLAG_EN to store the ADC out-of-range flag alongside each sample.
module adc_sample_fifo #(
  parameter int DATA_W = 12,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk_100MHz,
  input  logic              reset_n,
  input  logic              clk_10MHz,
  input  logic              enable,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              adc_otr,
  input  logic              clear_ovf,
  output logic [DATA_W-1:0] m_data,
  output logic              m_otr,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [ADDR_W:0]   fifo_count,
  output logic              overflow
);

`ifdef ADC_OTR_FLAG_EN
  localparam int ENTRY_W = DATA_W + 1;
`else
  localparam int ENTRY_W = DATA_W;
`endif

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]    count_q, count_d;
  logic               clk10_q, clk10_d;
  logic               overflow_q, overflow_d;
  logic               sample_stb, push, pop, full, wr_en, drop;
  logic [ENTRY_W-1:0] wr_word, head;

`ifdef ADC_OTR_FLAG_EN
  assign wr_word = {adc_otr, adc_data};
`else
  logic unused_otr;
  assign unused_otr = adc_otr;
  assign wr_word    = adc_data;
`endif

  always_comb begin
    clk10_d    = clk_10MHz;
    sample_stb = clk_10MHz & ~clk10_q;
    push       = sample_stb & enable;
    m_valid    = (count_q != '0);
    pop        = m_valid & m_ready;
    full       = (count_q == (ADDR_W+1)'(DEPTH));
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    wr_en      = push & (~full | pop);
    drop       = push & full & ~pop;
    wr_ptr_d   = wr_ptr_q + ADDR_W'(wr_en);
    rd_ptr_d   = rd_ptr_q + ADDR_W'(pop);
    count_d    = count_q;
    case ({wr_en, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    overflow_d = overflow_q;
    if (drop)           overflow_d = 1'b1;
    else if (clear_ovf) overflow_d = 1'b0;
  end

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      clk10_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      clk10_q    <= clk10_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is deliberately not reset; the empty gating on the outputs hides stale words.
  always_ff @(posedge clk_100MHz) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_word;
  end

  assign head       = mem_q[rd_ptr_q];
  assign m_data     = m_valid ? head[DATA_W-1:0] : '0;
`ifdef ADC_OTR_FLAG_EN
  assign m_otr      = m_valid & head[DATA_W];
`else
  assign m_otr      = 1'b0;
`endif
  assign fifo_count = count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_adc_sample_fifo.sv
// Bench for adc_sample_fifo: table-driven edge bursts, hand corner sequences, data scoreboard.
module tb_adc_sample_fifo;
  localparam int DATA_W = 12;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
`ifdef ADC_OTR_FLAG_EN
  localparam bit OTR_EN = 1'b1;
`else
  localparam bit OTR_EN = 1'b0;
`endif

  logic              clk_100MHz = 1'b0;
  logic              reset_n    = 1'b0;
  logic              clk_10MHz  = 1'b1;
  logic              enable     = 1'b1;
  logic [DATA_W-1:0] adc_data   = '0;
  logic              adc_otr    = 1'b0;
  logic              clear_ovf  = 1'b0;
  logic              m_ready    = 1'b0;
  logic [DATA_W-1:0] m_data;
  logic              m_otr, m_valid, overflow;
  logic [ADDR_W:0]   fifo_count;

  adc_sample_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk_100MHz(clk_100MHz), .reset_n(reset_n), .clk_10MHz(clk_10MHz), .enable(enable),
    .adc_data(adc_data), .adc_otr(adc_otr), .clear_ovf(clear_ovf), .m_data(m_data),
    .m_otr(m_otr), .m_valid(m_valid), .m_ready(m_ready), .fifo_count(fifo_count),
    .overflow(overflow)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Reference model: queue of {otr,data}, updated on the same edges as the DUT.
  logic [DATA_W:0] sb_q[$];
  logic            m_prev = 1'b1;
  logic            m_ovf  = 1'b0;

  always @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      sb_q.delete();
      m_prev = 1'b1;
      m_ovf  = 1'b0;
    end else begin
      automatic bit push = clk_10MHz && !m_prev && enable;
      automatic bit pop  = (sb_q.size() != 0) && m_ready;
      automatic bit full = (sb_q.size() == DEPTH);
      if (pop) begin
        automatic logic [DATA_W:0] e = sb_q.pop_front();
        chk("pop_data", int'(m_data), int'(e[DATA_W-1:0]));
        chk("pop_otr",  int'(m_otr),  OTR_EN ? int'(e[DATA_W]) : 0);
        chk("pop_valid", int'(m_valid), 1);
      end
      if (push && (!full || pop)) sb_q.push_back({adc_otr, adc_data});
      if (push && full && !pop) m_ovf = 1'b1;
      else if (clear_ovf)       m_ovf = 1'b0;
      m_prev = clk_10MHz;
    end
  end

  // Continuous state check away from the active edge, plus steady-state monitor.
  bit mon_on  = 1'b0;
  int mon_max = 0;
  int mon_vld = 0;
  always @(negedge clk_100MHz) begin
    chk("count",    int'(fifo_count), sb_q.size());
    chk("valid",    int'(m_valid),    int'(sb_q.size() != 0));
    chk("overflow", int'(overflow),   int'(m_ovf));
    if (sb_q.size() == 0) begin
      chk("empty_data", int'(m_data), 0);
      chk("empty_otr",  int'(m_otr),  0);
    end
    if (mon_on) begin
      if (int'(fifo_count) > mon_max) mon_max = int'(fifo_count);
      if (m_valid) mon_vld++;
    end
  end

  task automatic step();
    @(posedge clk_100MHz);
    #1;
  endtask

  task automatic gen_edge(input logic [DATA_W-1:0] d, input logic otr);
    clk_10MHz = 1'b0;
    repeat (5) step();
    clk_10MHz = 1'b1;
    adc_data  = d;
    adc_otr   = otr;
    repeat (5) step();
  endtask

  typedef struct {
    int n_edges;
    bit en;
    bit rdy;
    bit clr;
    int exp_count;
    bit exp_ovf;
  } vec_t;

  vec_t vecs[6];
  int   dcnt = 0;

  initial begin
    vecs[0] = '{17, 1'b1, 1'b0, 1'b0, 16, 1'b1};  // fill, 17th sample dropped
    vecs[1] = '{ 0, 1'b1, 1'b0, 1'b1, 16, 1'b0};  // clear with no drop
    vecs[2] = '{ 2, 1'b0, 1'b1, 1'b0,  0, 1'b0};  // drain
    vecs[3] = '{ 3, 1'b0, 1'b0, 1'b0,  0, 1'b0};  // disabled edges
    vecs[4] = '{ 2, 1'b1, 1'b0, 1'b0,  2, 1'b0};
    vecs[5] = '{ 1, 1'b1, 1'b1, 1'b0,  0, 1'b0};

    // Reset state, then release while clk_10MHz is already high.
    #2;
    chk("rst_count", int'(fifo_count), 0);
    chk("rst_valid", int'(m_valid), 0);
    chk("rst_ovf",   int'(overflow), 0);
    step();
    reset_n = 1'b1;
    repeat (3) step();
    chk("no_spurious", int'(fifo_count), 0);
    gen_edge(12'h0AB, 1'b0);
    chk("first_edge", int'(fifo_count), 1);

    // Async reset mid-operation discards buffered data.
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_count", int'(fifo_count), 0);
    chk("async_rst_valid", int'(m_valid), 0);
    chk("async_rst_data",  int'(m_data), 0);
    step();
    reset_n = 1'b1;
    step();

    for (int i = 0; i < 6; i++) begin
      enable  = vecs[i].en;
      m_ready = vecs[i].rdy;
      for (int e = 0; e < vecs[i].n_edges; e++) begin
        gen_edge(DATA_W'(dcnt), 1'b0);
        dcnt++;
      end
      if (vecs[i].clr) begin
        clear_ovf = 1'b1;
        step();
        clear_ovf = 1'b0;
      end
      step();
      chk($sformatf("vec%0d_count", i), int'(fifo_count), vecs[i].exp_count);
      chk($sformatf("vec%0d_ovf", i),   int'(overflow),   int'(vecs[i].exp_ovf));
      if (i == 1) begin
        // Full FIFO: edge lands with m_ready=1 for exactly that cycle.
        clk_10MHz = 1'b0;
        repeat (5) step();
        clk_10MHz = 1'b1;
        adc_data  = 12'h777;
        m_ready   = 1'b1;
        step();
        m_ready   = 1'b0;
        repeat (4) step();
        chk("full_pp_count", int'(fifo_count), 16);
        chk("full_pp_ovf",   int'(overflow), 0);
      end
    end

    // Drop coincident with clear_ovf: set wins.
    enable  = 1'b1;
    m_ready = 1'b0;
    for (int e = 0; e < DEPTH; e++) gen_edge(DATA_W'(100 + e), 1'b0);
    chk("refill_count", int'(fifo_count), 16);
    clk_10MHz = 1'b0;
    repeat (5) step();
    clk_10MHz = 1'b1;
    clear_ovf = 1'b1;
    step();
    clear_ovf = 1'b0;
    chk("set_beats_clr", int'(overflow), 1);
    clear_ovf = 1'b1;
    step();
    clear_ovf = 1'b0;
    chk("clr_after", int'(overflow), 0);
    m_ready = 1'b1;
    repeat (20) step();
    chk("drained", int'(fifo_count), 0);

    // Divider-style steady state with constant data.
    mon_on = 1'b1;
    for (int e = 0; e < 5; e++) gen_edge(12'h123, 1'b0);
    step();
    mon_on = 1'b0;
    chk("steady_max_count", mon_max, 1);
    chk("steady_valid_cycles", mon_vld, 5);

    // Out-of-range flag travels with the sample.
    m_ready = 1'b0;
    gen_edge(12'hFFF, 1'b1);
    chk("otr_data", int'(m_data), 'hFFF);
    chk("otr_flag", int'(m_otr), OTR_EN ? 1 : 0);
    adc_otr = 1'b0;
    m_ready = 1'b1;
    repeat (3) step();
    chk("final_empty", int'(m_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
